// File: rtl/bram_stream_reader.sv
// Streams a burst of words out of a registered-output BRAM.
// A 2-entry FIFO decouples BRAM read latency from downstream backpressure.
module bram_stream_reader #(
    parameter int NUM_BLOCKS = 16,
    localparam int ADDR_W = 8 + $clog2(NUM_BLOCKS),
    localparam int DEPTH = 256 * NUM_BLOCKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              out_valid,
    output logic [15:0]       out_data,
    output logic              out_last,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [ADDR_W:0]   iss_q, iss_d;
    logic [ADDR_W:0]   ret_q, ret_d;
    logic              infl_q;
    logic              zdone_q, zdone_d;

    logic [15:0]       fifo_q [2];
    logic              wp_q, rp_q;
    logic [1:0]        cnt_q, cnt_d;

    logic              push, pop;
    logic [2:0]        occ;

    // The BRAM word requested last cycle lands in the FIFO now.
    assign push      = infl_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = fifo_q[rp_q];
    assign out_last  = out_valid && (ret_q == CNT_ONE);
    assign pop       = out_valid & out_ready;
    assign busy      = (state_q != IDLE);
    assign rd_addr   = rd_en ? addr_q : last_addr_q;
    assign occ       = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};

    // Next-state, read issue and completion logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        iss_d       = iss_q;
        ret_d       = ret_q;
        zdone_d     = 1'b0;
        rd_en       = 1'b0;
        done        = zdone_q;
        if (pop) begin
            ret_d = ret_q - CNT_ONE;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        addr_d  = base_addr;
                        iss_d   = length;
                        ret_d   = length;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (iss_q != '0 && occ < 3'd2) begin
                    rd_en       = 1'b1;
                    last_addr_d = addr_q;
                    addr_d      = (addr_q == ADDR_TOP) ? '0 : addr_q + 1'b1;
                    iss_d       = iss_q - CNT_ONE;
                end
                if (iss_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && ret_q == CNT_ONE) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, address and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            iss_q       <= '0;
            ret_q       <= '0;
            infl_q      <= 1'b0;
            zdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            iss_q       <= iss_d;
            ret_q       <= ret_d;
            infl_q      <= rd_en;
            zdone_q     <= zdone_d;
        end
    end

    // Two-entry output FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wp_q] <= rd_data;
                wp_q         <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_d;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && cnt_q == 2'd2)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural BRAM.
// Memory holds mem[i] = i; each task checks one scenario inline.
module tb_bram_stream_reader;

    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data = '0;
    logic          out_valid;
    logic [15:0]   out_data;
    logic          out_last;
    logic          out_ready = 1'b0;

    int checks = 0;
    int passes = 0;

    logic [15:0] mem [DEPTH];

    bram_stream_reader #(.NUM_BLOCKS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic drive_start(input logic [AW-1:0] b, input logic [AW:0] l);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        length    = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({busy, done, rd_en, out_valid, out_last} !== 5'b0)
            $display("FAIL reset_ctl got %b want 00000", {busy, done, rd_en, out_valid, out_last});
        else passes++;
        checks++; if (rd_addr !== '0) $display("FAIL reset_addr got %h want 000", rd_addr);
        else passes++;
        checks++; if (out_data !== 16'h0) $display("FAIL reset_data got %h want 0000", out_data);
        else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rd_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_idle got rd_en=%b busy=%b want 0 0", rd_en, busy);
        else passes++;
    endtask

    // Burst with out_ready held high: exact cycle-by-cycle expectations.
    task automatic run_burst(input string nm, input int b, input int l);
        logic          e_en, e_v, e_done, e_busy;
        logic [AW-1:0] e_addr;
        logic [15:0]   e_data;
        out_ready = 1'b1;
        drive_start(AW'(b), (AW + 1)'(l));
        for (int c = 1; c <= l + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            e_en   = (c <= l);
            e_v    = (c >= 3 && c <= l + 2);
            e_done = (c == l + 2);
            e_busy = (c <= l + 2);
            e_addr = AW'(b + c - 1);
            e_data = 16'((b + c - 3) % DEPTH);
            checks++; if (rd_en !== e_en)
                $display("FAIL %s_rd_en c=%0d got %b want %b", nm, c, rd_en, e_en);
            else passes++;
            if (e_en) begin
                checks++; if (rd_addr !== e_addr)
                    $display("FAIL %s_rd_addr c=%0d got %h want %h", nm, c, rd_addr, e_addr);
                else passes++;
            end
            checks++; if (out_valid !== e_v)
                $display("FAIL %s_valid c=%0d got %b want %b", nm, c, out_valid, e_v);
            else passes++;
            if (e_v) begin
                checks++; if (out_data !== e_data)
                    $display("FAIL %s_data c=%0d got %h want %h", nm, c, out_data, e_data);
                else passes++;
            end
            checks++; if (out_last !== e_done)
                $display("FAIL %s_last c=%0d got %b want %b", nm, c, out_last, e_done);
            else passes++;
            checks++; if (done !== e_done)
                $display("FAIL %s_done c=%0d got %b want %b", nm, c, done, e_done);
            else passes++;
            checks++; if (busy !== e_busy)
                $display("FAIL %s_busy c=%0d got %b want %b", nm, c, busy, e_busy);
            else passes++;
        end
    endtask

    task automatic test_basic();
        run_burst("basic", 'h010, 4);
    endtask

    task automatic test_wrap();
        run_burst("wrap", 'hFFE, 4);
    endtask

    task automatic test_full_depth();
        run_burst("full", 'h123, DEPTH);
    endtask

    task automatic test_backpressure();
        int          got = 0;
        int          dn = 0;
        int          maxc = 0;
        logic        stall = 1'b0;
        logic [15:0] held = '0;
        drive_start(AW'('h040), (AW + 1)'(8));
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start     = 1'b0;
            out_ready = (c % 4 == 1) || (c % 4 == 0);
            #1;
            if (int'(dut.cnt_q) > maxc) maxc = int'(dut.cnt_q);
            if (stall) begin
                checks++; if (out_data !== held)
                    $display("FAIL bp_stable c=%0d got %h want %h", c, out_data, held);
                else passes++;
            end
            if (out_valid && out_ready) begin
                checks++; if (out_data !== 16'('h040 + got))
                    $display("FAIL bp_data k=%0d got %h want %h", got, out_data, 16'('h040 + got));
                else passes++;
                checks++; if (out_last !== (got == 7))
                    $display("FAIL bp_last k=%0d got %b want %b", got, out_last, got == 7);
                else passes++;
                got++;
            end
            if (done) dn++;
            stall = out_valid && !out_ready;
            held  = out_data;
        end
        checks++; if (got != 8) $display("FAIL bp_count got %0d want 8", got);
        else passes++;
        checks++; if (dn != 1) $display("FAIL bp_done got %0d want 1", dn);
        else passes++;
        checks++; if (maxc > 2) $display("FAIL bp_fifo_max got %0d want <=2", maxc);
        else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL bp_busy_end got %b want 0", busy);
        else passes++;
        out_ready = 1'b1;
    endtask

    task automatic test_zero_len();
        out_ready = 1'b1;
        drive_start(AW'('h300), '0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++; if (done !== (c == 1))
                $display("FAIL zero_done c=%0d got %b want %b", c, done, c == 1);
            else passes++;
            checks++; if ({rd_en, out_valid, busy} !== 3'b0)
                $display("FAIL zero_quiet c=%0d got %b want 000", c, {rd_en, out_valid, busy});
            else passes++;
        end
    endtask

    task automatic test_busy_start();
        int iss = 0;
        int got = 0;
        int dn = 0;
        out_ready = 1'b1;
        drive_start(AW'('h080), (AW + 1)'(6));
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = (c == 2);
            if (c == 2) begin
                base_addr = AW'('h100);
                length    = (AW + 1)'(3);
            end
            #1;
            if (rd_en) begin
                checks++; if (rd_addr !== AW'('h080 + iss))
                    $display("FAIL busy_addr k=%0d got %h want %h", iss, rd_addr, AW'('h080 + iss));
                else passes++;
                iss++;
            end
            if (out_valid && out_ready) begin
                checks++; if (out_data !== 16'('h080 + got))
                    $display("FAIL busy_data k=%0d got %h want %h", got, out_data, 16'('h080 + got));
                else passes++;
                got++;
            end
            if (done) dn++;
        end
        start = 1'b0;
        checks++; if (iss != 6) $display("FAIL busy_issued got %0d want 6", iss);
        else passes++;
        checks++; if (got != 6) $display("FAIL busy_words got %0d want 6", got);
        else passes++;
        checks++; if (dn != 1) $display("FAIL busy_done got %0d want 1", dn);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int got = 0;
        out_ready = 1'b1;
        drive_start(AW'('h200), (AW + 1)'(10));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (out_valid && out_ready) got++;
        end
        checks++; if (got != 3) $display("FAIL rstmid_pre got %0d want 3", got);
        else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, rd_en, out_valid, out_last} !== 5'b0)
            $display("FAIL rstmid_ctl got %b want 00000", {busy, done, rd_en, out_valid, out_last});
        else passes++;
        checks++; if (rd_addr !== '0 || out_data !== 16'h0)
            $display("FAIL rstmid_bus got addr=%h data=%h want 000 0000", rd_addr, out_data);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            checks++; if ({rd_en, out_valid, busy} !== 3'b0)
                $display("FAIL rstmid_idle c=%0d got %b want 000", c, {rd_en, out_valid, busy});
            else passes++;
        end
        run_burst("rstnew", 'h020, 2);
    endtask

    initial for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i);

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_backpressure();
        test_busy_start();
        test_reset_mid();
        test_full_depth();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter NUM_BLOCKS, default 16, is the number of 256x16 BRAM blocks in the target memory.
REQ-002 Local ADDR_W = 8 + clog2(NUM_BLOCKS) sets the address width; DEPTH = 256*NUM_BLOCKS.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  single-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_W  first word address; latched when start is accepted.
REQ-007 length  in  ADDR_W+1  number of words in the burst (0..DEPTH); latched when start is accepted.
REQ-008 busy  out  1  high in RUN and DRAIN.
REQ-009 done  out  1  one-cycle pulse at the end of a burst.
REQ-010 rd_en  out  1  BRAM read enable.
REQ-011 rd_addr  out  ADDR_W  BRAM read address.
REQ-012 rd_data  in  16  BRAM registered read data, valid in the cycle after rd_en.
REQ-013 out_valid  out  1  stream word available.
REQ-014 out_data  out  16  stream word.
REQ-015 out_last  out  1  qualifies the final word of the burst while out_valid is high.
REQ-016 out_ready  in  1  downstream accept; a transfer occurs when out_valid and out_ready are both high.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
REQ-018 Start in IDLE with length>0: latch the burst parameters, go to RUN; issue counter = length, return counter = length.
REQ-019 Start in IDLE with length=0: no reads issued; done pulses in the next cycle; stay in IDLE.
REQ-020 Start while busy: ignore it; latched parameters are unchanged.
REQ-021 Buffering: 2-entry output FIFO; one read in flight at most per cycle (inflight flag = rd_en of previous cycle).
REQ-022 In RUN, rd_en asserts when issue counter > 0 and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
REQ-023 On each issued read: rd_addr = current address; the address then increments modulo DEPTH (DEPTH-1 wraps to 0); the issue counter decrements.
REQ-024 rd_data is written into the FIFO on the cycle after rd_en; a simultaneous push and pop keeps the count unchanged.
REQ-025 The FIFO never overflows; any push while full is a design error (assertion).
REQ-026 out_valid = FIFO non-empty; out_data = FIFO head; out_data is stable while out_valid is high and out_ready is low.
REQ-027 out_last is high when out_valid is high and the return counter = 1.
REQ-028 Each transfer decrements the return counter.
REQ-029 RUN goes to DRAIN when the issue counter reaches 0.
REQ-030 DRAIN goes to IDLE on the transfer that brings the return counter to 0; done pulses in that same cycle.
REQ-031 Latency: start sampled at edge N -> rd_en high in cycle N+1 -> out_valid high from cycle N+3.
REQ-032 Throughput: with out_ready held high, one word per cycle after the first word.
REQ-033 rd_en stays low in IDLE and DRAIN; rd_addr holds its last value when rd_en is low.
REQ-034 length = DEPTH reads every word exactly once, wrapping through 0.

Reset
REQ-035 When rst_n goes low, at any time including mid-burst, all outputs go low or zero, the FIFO empties, the counters clear and the state becomes IDLE.
REQ-036 After rst_n goes high, no read is issued until a new start is accepted; an in-flight BRAM word returning after reset is discarded.

Verification
REQ-037 Basic burst: BRAM preloaded with mem[i]=i; base=0x010, length=4, out_ready=1 -> rd_en cycles N+1..N+4; out_data 0x0010..0x0013 in consecutive cycles; out_last with 0x0013; done in the same cycle.
REQ-038 Wrap: NUM_BLOCKS=16, base=0xFFE, length=4 -> rd_addr sequence 0xFFE, 0xFFF, 0x000, 0x001; data order matches.
REQ-039 Backpressure: length=8, out_ready toggled 1-0-0-1 repeating -> all 8 words in order, none lost or duplicated; fifo_count never exceeds 2; out_data stable during stalls.
REQ-040 Zero length: start with length=0 -> done the next cycle; rd_en and out_valid never assert.
REQ-041 Busy start: second start with base=0x100 during a burst -> ignored; original burst completes unchanged.
REQ-042 Reset mid-burst: rst_n low after 3 of 10 words -> outputs low immediately; after release, a new burst base=0x020, length=2 returns 0x0020, 0x0021 only.
